// File: rtl/red_pitaya_daisy_pkg.sv
// red_pitaya_daisy_pkg: shared daisy-chain framing constants, FSM encodings and helpers
package red_pitaya_daisy_pkg;
  localparam logic [7:0]  DAISY_SYNC  = 8'hA5;
  localparam logic [15:0] DAISY_IDLE  = 16'h0000;
  localparam logic [15:0] DAISY_TRAIN = 16'h00FF;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CSUM    = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;
  typedef struct packed {
    logic        last;
    logic [15:0] dat;
  } daisy_word_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/red_pitaya_daisy_rx_deframer_if.sv
// red_pitaya_daisy_rx_deframer_if: word input, payload stream and status bundle of the deframer
interface red_pitaya_daisy_rx_deframer_if;
  logic        cfg_en_i;
  logic        par_dv_i;
  logic [15:0] par_dat_i;
  logic [15:0] m_dat_o;
  logic        m_last_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [15:0] frm_ok_o;
  logic [15:0] frm_err_o;
  logic [15:0] frm_ovf_o;
  logic        busy_o;
  modport master (
    output cfg_en_i, par_dv_i, par_dat_i, m_ready_i,
    input  m_dat_o, m_last_o, m_valid_o, frm_ok_o, frm_err_o, frm_ovf_o, busy_o
  );
  modport slave (
    input  cfg_en_i, par_dv_i, par_dat_i, m_ready_i,
    output m_dat_o, m_last_o, m_valid_o, frm_ok_o, frm_err_o, frm_ovf_o, busy_o
  );
endinterface

// File: rtl/red_pitaya_daisy_dpram.sv
// red_pitaya_daisy_dpram: simple dual-port RAM, one write port, one registered read port
module red_pitaya_daisy_dpram #(
  parameter int DW    = 17,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdat;
  // write port and read port; read data holds when i_re is low
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    if (i_re) r_rdat <= r_mem[i_raddr];
  end
  assign o_rdat = r_rdat;
endmodule

// File: rtl/red_pitaya_daisy_rx_deframer.sv
// red_pitaya_daisy_rx_deframer: checksum-verified frame extraction with speculative FIFO commit
module red_pitaya_daisy_rx_deframer
  import red_pitaya_daisy_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic clk_i,
  input logic rstn_i,
  red_pitaya_daisy_rx_deframer_if.slave bus
);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [1:0]  r_state;
  logic [7:0]  r_rem;
  logic [7:0]  r_drop_rem;
  logic [15:0] r_csum;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_wr_commit;
  logic [AW:0] r_rd_ptr;
  logic        r_ram_v;
  logic        r_m_valid;
  logic [15:0] r_m_dat;
  logic        r_m_last;
  logic [15:0] r_ok;
  logic [15:0] r_err;
  logic [15:0] r_ovf;
  logic        w_beat;
  logic        w_hdr;
  logic        w_full;
  logic        w_we;
  logic        w_csum_ok;
  logic        w_commit;
  logic        w_bad;
  logic        w_drop_end;
  logic        w_readable;
  logic        w_rd;
  logic        w_ld;
  daisy_word_t w_wword;
  daisy_word_t w_rword;
  assign w_beat     = bus.cfg_en_i && bus.par_dv_i;
  assign w_hdr      = (bus.par_dat_i[15:8] == DAISY_SYNC) && (bus.par_dat_i[7:0] != 8'd0);
  assign w_full     = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
  assign w_we       = w_beat && (r_state == ST_PAYLOAD) && !w_full;
  assign w_csum_ok  = bus.par_dat_i == r_csum;
  assign w_commit   = w_beat && (r_state == ST_CSUM) && w_csum_ok;
  assign w_bad      = w_beat && (r_state == ST_CSUM) && !w_csum_ok;
  assign w_drop_end = w_beat && (r_state == ST_DROP) && (r_drop_rem == 8'd1);
  assign w_readable = r_rd_ptr != r_wr_commit;
  assign w_ld       = r_ram_v && (!r_m_valid || bus.m_ready_i);
  assign w_rd       = w_readable && (!r_ram_v || w_ld);
  assign w_wword    = '{last: (r_rem == 8'd1), dat: bus.par_dat_i};
  red_pitaya_daisy_dpram #(.DW(17), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i  (clk_i),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr[AW-1:0]),
    .i_wdat (w_wword),
    .i_re   (w_rd),
    .i_raddr(r_rd_ptr[AW-1:0]),
    .o_rdat (w_rword)
  );
  // frame parser: header, payload with running checksum, checksum check, overflow discard
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_rem      <= 8'd0;
      r_drop_rem <= 8'd0;
      r_csum     <= 16'd0;
    end else if (!bus.cfg_en_i) begin
      r_state <= ST_IDLE;
    end else if (bus.par_dv_i) begin
      case (r_state)
        ST_IDLE: if (w_hdr) begin
          r_state <= ST_PAYLOAD;
          r_rem   <= bus.par_dat_i[7:0];
          r_csum  <= bus.par_dat_i;
        end
        ST_PAYLOAD: if (w_full) begin
          r_state    <= ST_DROP;
          r_drop_rem <= r_rem;
        end else begin
          r_csum  <= r_csum ^ bus.par_dat_i;
          r_rem   <= r_rem - 8'd1;
          r_state <= (r_rem == 8'd1) ? ST_CSUM : ST_PAYLOAD;
        end
        ST_CSUM: r_state <= ST_IDLE;
        default: begin
          r_drop_rem <= r_drop_rem - 8'd1;
          r_state    <= (r_drop_rem == 8'd1) ? ST_IDLE : ST_DROP;
        end
      endcase
    end
  end
  // FIFO pointers: speculative write, commit on good checksum, rollback touches only wr_ptr
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (!bus.cfg_en_i || w_bad || w_drop_end) r_wr_ptr <= r_wr_commit;
      else if (w_we) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_commit) r_wr_commit <= r_wr_ptr;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
  // output pipeline: RAM read stage then output register, held while stalled
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ram_v   <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_dat   <= 16'd0;
      r_m_last  <= 1'b0;
    end else begin
      r_ram_v <= w_rd || (r_ram_v && !w_ld);
      if (w_ld) begin
        r_m_valid <= 1'b1;
        r_m_dat   <= w_rword.dat;
        r_m_last  <= w_rword.last;
      end else if (bus.m_ready_i) begin
        r_m_valid <= 1'b0;
      end
    end
  end
  // saturating frame outcome counters
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ok  <= 16'd0;
      r_err <= 16'd0;
      r_ovf <= 16'd0;
    end else begin
      if (w_commit) r_ok <= sat_inc(r_ok);
      if (w_bad) r_err <= sat_inc(r_err);
      if (w_drop_end) r_ovf <= sat_inc(r_ovf);
    end
  end
  assign bus.m_valid_o = r_m_valid;
  assign bus.m_dat_o   = r_m_dat;
  assign bus.m_last_o  = r_m_last;
  assign bus.frm_ok_o  = r_ok;
  assign bus.frm_err_o = r_err;
  assign bus.frm_ovf_o = r_ovf;
  assign bus.busy_o    = r_state != ST_IDLE;
endmodule

// File: tb/tb_red_pitaya_daisy_rx_deframer.sv
// tb_red_pitaya_daisy_rx_deframer: directed frames checked against a frame-level model
module tb_red_pitaya_daisy_rx_deframer;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  red_pitaya_daisy_rx_deframer_if bus();
  red_pitaya_daisy_rx_deframer #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );
  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  bit rnd = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got[$];
  logic [15:0] pay[$];
  logic [15:0] e_ok, e_err, e_ovf, acc;
  bit in_fr;
  int len;
  logic [16:0] prev;
  bit stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] sinc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // frame-level reference: collect a whole frame, decide at its checksum word
  always @(posedge clk) begin
    if (!rstn) begin
      in_fr = 0; pay.delete(); exp_q.delete();
      e_ok = 0; e_err = 0; e_ovf = 0; acc = 0; len = 0;
    end else if (!bus.cfg_en_i) begin
      in_fr = 0; pay.delete();
    end else if (bus.par_dv_i) begin
      if (!in_fr) begin
        if (bus.par_dat_i[15:8] == 8'hA5 && bus.par_dat_i[7:0] != 0) begin
          in_fr = 1; len = int'(bus.par_dat_i[7:0]); acc = bus.par_dat_i; pay.delete();
        end
      end else if (pay.size() < len) begin
        pay.push_back(bus.par_dat_i); acc ^= bus.par_dat_i;
      end else begin
        in_fr = 0;
        if (len > DEPTH) e_ovf = sinc(e_ovf);
        else if (bus.par_dat_i == acc) begin
          for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pay[i]});
          e_ok = sinc(e_ok);
        end else e_err = sinc(e_err);
      end
    end
  end

  // per-cycle comparison of counters, busy, stream order and stall stability
  always @(negedge clk) if (chk_en) begin
    logic [16:0] act;
    act = {bus.m_last_o, bus.m_dat_o};
    check("frm_ok", bus.frm_ok_o, e_ok);
    check("frm_err", bus.frm_err_o, e_err);
    check("frm_ovf", bus.frm_ovf_o, e_ovf);
    check("busy", bus.busy_o, in_fr);
    if (stall && rstn) begin
      check("hold_valid", bus.m_valid_o, 1);
      check("hold_data", act, prev);
    end
    if (bus.m_valid_o && bus.m_ready_i) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_out: got %h want none", act);
      end else check("out_word", act, exp_q.pop_front());
      got.push_back(act);
    end
    stall = bus.m_valid_o && !bus.m_ready_i;
    prev = act;
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd) bus.m_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic beat(input logic [15:0] w);
    bus.par_dv_i = 1; bus.par_dat_i = w;
    tick();
    bus.par_dv_i = 0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 300 && got.size() < n; i++) tick();
    check("drain_count", got.size(), n);
  endtask

  task automatic good3();
    beat(16'hA503); beat(16'h1111); beat(16'h2222); beat(16'h3333); beat(16'hA503);
  endtask

  initial begin
    bus.cfg_en_i = 1; bus.par_dv_i = 0; bus.par_dat_i = 0; bus.m_ready_i = 1;
    repeat (3) tick();
    chk_en = 1;
    check("rst_valid", bus.m_valid_o, 0);
    check("rst_dat", bus.m_dat_o, 0);
    check("rst_last", bus.m_last_o, 0);
    check("rst_busy", bus.busy_o, 0);
    rstn = 1; tick();
    beat(16'h00FF); beat(16'h0000); beat(16'hA500); beat(16'h1234); tick();
    check("junk_busy", bus.busy_o, 0);
    check("junk_cnt", {bus.frm_ok_o, bus.frm_err_o}, 0);
    check("junk_ovf", bus.frm_ovf_o, 0);
    good3();
    wait_got(3);
    check("good_w0", got[0], 17'h01111);
    check("good_w1", got[1], 17'h02222);
    check("good_w2", got[2], 17'h13333);
    check("good_ok", bus.frm_ok_o, 1);
    got.delete();
    beat(16'hA503); beat(16'h1111); beat(16'h2222); beat(16'h3333); beat(16'hA504);
    repeat (6) tick();
    check("err_noout", got.size(), 0);
    check("err_cnt", bus.frm_err_o, 1);
    beat(16'hA502); beat(16'h0AAA); beat(16'h0BBB); beat(16'hA413);
    wait_got(2);
    check("after_err_w1", got[1], 17'h10BBB);
    got.delete();
    bus.m_ready_i = 0;
    beat(16'hA50A);
    for (int i = 1; i <= 10; i++) beat(16'(i));
    beat(16'h0000);
    repeat (2) tick();
    check("ovf_cnt", bus.frm_ovf_o, 1);
    check("ovf_noout", got.size(), 0);
    good3();
    repeat (5) tick();
    check("ovf_pending", bus.m_valid_o, 1);
    bus.m_ready_i = 1;
    wait_got(3);
    check("ovf_after_w2", got[2], 17'h13333);
    got.delete();
    rnd = 1;
    beat(16'hA504); beat(16'h0101); beat(16'h0202); beat(16'h0303); beat(16'h0404); beat(16'hA100);
    beat(16'hA504); beat(16'h1010); beat(16'h2020); beat(16'h3030); beat(16'h4040); beat(16'hE544);
    wait_got(8);
    rnd = 0; bus.m_ready_i = 1;
    check("bp_last4", got[3], 17'h10404);
    check("bp_mid5", got[4], 17'h01010);
    check("bp_last8", got[7], 17'h14040);
    got.delete();
    rstn = 0; repeat (2) tick(); rstn = 1; tick();
    beat(16'hA503); beat(16'h1111); beat(16'h2222);
    bus.cfg_en_i = 0; tick(); bus.cfg_en_i = 1;
    beat(16'hA502); beat(16'h0AAA); beat(16'h0BBB); beat(16'hA413);
    wait_got(2);
    check("abort_w0", got[0], 17'h00AAA);
    check("abort_ok", bus.frm_ok_o, 1);
    check("abort_err", bus.frm_err_o, 0);
    check("abort_ovf", bus.frm_ovf_o, 0);
    got.delete();
    beat(16'hA503); beat(16'h1111);
    rstn = 0; repeat (2) tick();
    check("rst2_valid", bus.m_valid_o, 0);
    check("rst2_dat", bus.m_dat_o, 0);
    check("rst2_last", bus.m_last_o, 0);
    check("rst2_ok", bus.frm_ok_o, 0);
    check("rst2_busy", bus.busy_o, 0);
    rstn = 1; tick();
    good3();
    wait_got(3);
    check("rst2_after_w0", got[0], 17'h01111);
    check("rst2_after_ok", bus.frm_ok_o, 1);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
